uart_rx: RTL and testbench

//  Serial-to-parallel UART receiver, the receiving end of the peripheral's TX/baud path.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_rx_if.sv | 40 ++++
 rtl/uart_rx_bit_timer.sv | 45 ++++
 rtl/uart_rx.sv | 156 +++++++++++++++
 tb/tb_uart_rx.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions, used by the receiver and the transmitter.
//   uart_state_t         : frame FSM states (IDLE, START, DATA, STOP)
//   DATA_BITS            : payload bits per frame (8N1)
//   DEFAULT_CLKS_PER_BIT : 100 MHz clock / 115200 baud
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

    localparam int DATA_BITS            = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 868;

endpackage

// File: rtl/uart_rx_if.sv
// -----------------------------------------------------------------------------
// uart_rx_if
// Bus-side interface of the UART receiver.
//   rd_ack    : bus has consumed rx_data (driven by master)
//   rx_data   : last received byte
//   rx_valid  : rx_data holds an unread byte (level)
//   frame_err : one-cycle pulse, stop bit sampled low
//   overrun   : sticky, a byte was overwritten before being read
//   busy      : a frame is being received
// Modports: master = register/bus side, slave = receiver.
// -----------------------------------------------------------------------------
interface uart_rx_if;
    import uart_pkg::*;

    logic                 rd_ack;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 frame_err;
    logic                 overrun;
    logic                 busy;

    modport master (
        output rd_ack,
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  overrun,
        input  busy
    );

    modport slave (
        input  rd_ack,
        output rx_data,
        output rx_valid,
        output frame_err,
        output overrun,
        output busy
    );

endinterface

// File: rtl/uart_rx_bit_timer.sv
// -----------------------------------------------------------------------------
// rx_bit_timer
// Loadable down-counter that paces the receiver's bit sampling.
//   clk         in  system clock
//   rst         in  synchronous reset, active-low
//   i_load_half in  load CLKS_PER_BIT/2 - 1 (centre of the start bit)
//   i_load_full in  load CLKS_PER_BIT - 1 (one full bit period)
//   o_tick      out counter has reached zero
// The counter holds at zero rather than wrapping, so o_tick stays high while
// the FSM idles and no spurious reload happens.
// -----------------------------------------------------------------------------
module rx_bit_timer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load_half,
    input  logic i_load_full,
    output logic o_tick
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] HALF_VAL = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_VAL = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_load_half) begin
            r_cnt <= HALF_VAL;
        end else if (i_load_full) begin
            r_cnt <= FULL_VAL;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_tick = (r_cnt == '0);

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// 8N1 UART receiver: synchronizes rxd, samples each bit at mid-bit, and holds
// the received byte in a one-entry buffer until the bus acknowledges it.
//   clk  in  system clock, rising edge
//   rst  in  synchronous reset, active-low
//   rxd  in  serial input, idle high, asynchronous to clk
//   bus      uart_rx_if.slave (rd_ack in; rx_data, rx_valid, frame_err,
//            overrun, busy out)
// -----------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    uart_rx_if.slave   bus
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_rxs_prev;
    logic                   w_rxs;
    logic                   w_fall;

    uart_state_t            r_state;
    uart_state_t            w_state_nxt;

    logic [2:0]             r_bit_idx;
    logic [DATA_BITS-1:0]   r_shreg;
    logic [DATA_BITS-1:0]   r_rx_data;
    logic                   r_rx_valid;
    logic                   r_frame_err;
    logic                   r_overrun;

    logic                   w_tick;
    logic                   w_load_half;
    logic                   w_load_full;
    logic                   w_shift;
    logic                   w_stop_tick;
    logic                   w_busy;
    logic                   w_last_bit;

    // Synchronizer presets to idle-high so reset never looks like a start edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync     <= '1;
            r_rxs_prev <= 1'b1;
        end else begin
            r_sync     <= {r_sync[SYNC_STAGES-2:0], rxd};
            r_rxs_prev <= w_rxs;
        end
    end

    assign w_rxs      = r_sync[SYNC_STAGES-1];
    assign w_fall     = r_rxs_prev & ~w_rxs;
    assign w_last_bit = (r_bit_idx == 3'(DATA_BITS - 1));

    rx_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_timer (
        .clk         (clk),
        .rst         (rst),
        .i_load_half (w_load_half),
        .i_load_full (w_load_full),
        .o_tick      (w_tick)
    );

    // FSM: state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:  if (w_fall) w_state_nxt = START;
            START: if (w_tick) w_state_nxt = w_rxs ? IDLE : DATA;
            DATA:  if (w_tick && w_last_bit) w_state_nxt = STOP;
            STOP:  if (w_tick) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // FSM: outputs. The timer reloads on every state entry, including the
    // DATA->STOP transition after the last data bit.
    always_comb begin
        w_load_half = 1'b0;
        w_load_full = 1'b0;
        w_shift     = 1'b0;
        w_stop_tick = 1'b0;
        w_busy      = (r_state != IDLE);
        case (r_state)
            IDLE:  w_load_half = w_fall;
            START: w_load_full = w_tick & ~w_rxs;
            DATA: begin
                w_load_full = w_tick;
                w_shift     = w_tick;
            end
            STOP:  w_stop_tick = w_tick;
            default: ;
        endcase
    end

    // Shift register fills from the MSB so the first (LSB) bit ends at bit 0.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_bit_idx <= '0;
        end else if (w_load_half) begin
            r_bit_idx <= '0;
        end else if (w_shift) begin
            r_bit_idx <= r_bit_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_shift) begin
            r_shreg <= {w_rxs, r_shreg[DATA_BITS-1:1]};
        end
    end

    // Holding buffer: a completing frame beats a simultaneous rd_ack, and the
    // ack in that cycle suppresses overrun.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_stop_tick & ~w_rxs;
            if (w_stop_tick && w_rxs) begin
                r_rx_data  <= r_shreg;
                r_rx_valid <= 1'b1;
                r_overrun  <= bus.rd_ack ? 1'b0 : (r_overrun | r_rx_valid);
            end else if (bus.rd_ack) begin
                r_rx_valid <= 1'b0;
                r_overrun  <= 1'b0;
            end
        end
    end

    assign bus.rx_data   = r_rx_data;
    assign bus.rx_valid  = r_rx_valid;
    assign bus.frame_err = r_frame_err;
    assign bus.overrun   = r_overrun;
    assign bus.busy      = w_busy;

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Directed bench for uart_rx at 100 MHz, 868 clocks per bit.
// -----------------------------------------------------------------------------
module tb_uart_rx;
    import uart_pkg::*;

    localparam int CPB = 868;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rxd = 1'b1;

    uart_rx_if bus_if ();

    uart_rx #(
        .CLKS_PER_BIT (CPB),
        .SYNC_STAGES  (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .rxd (rxd),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    int   total      = 0;
    int   bad        = 0;
    int   cyc        = 0;
    int   fe_cnt     = 0;
    int   rise_cyc   = -1;
    logic prev_valid = 1'b0;

    always @(posedge clk) cyc++;

    // Observers: count frame_err high cycles and note when rx_valid rises.
    always @(negedge clk) begin
        if (bus_if.frame_err === 1'b1) fe_cnt++;
        if (bus_if.rx_valid === 1'b1 && prev_valid !== 1'b1) rise_cyc = cyc;
        prev_valid = bus_if.rx_valid;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: run did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_ack();
        bus_if.rd_ack = 1'b1;
        @(negedge clk);
        bus_if.rd_ack = 1'b0;
    endtask

    // Drives one 8N1 frame starting at a negedge. With ack set, the byte is
    // checked and acknowledged mid stop bit, keeping the frame length exact.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input bit ack);
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
        rxd = stop_bit;
        if (ack) begin
            repeat (CPB / 2 + 10) @(negedge clk);
            check("bb_valid", 32'(bus_if.rx_valid), 32'd1);
            check("bb_data", 32'(bus_if.rx_data), 32'(b));
            pulse_ack();
            check("bb_cleared", 32'(bus_if.rx_valid), 32'd0);
            repeat (CPB - CPB / 2 - 11) @(negedge clk);
        end else begin
            repeat (CPB) @(negedge clk);
        end
        rxd = 1'b1;
    endtask

    initial begin
        int start_cyc;
        int fe0;

        // Reset with rxd low
        bus_if.rd_ack = 1'b0;
        rst = 1'b0;
        rxd = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(bus_if.rx_valid), 32'd0);
        check("rst_data", 32'(bus_if.rx_data), 32'd0);
        check("rst_ferr", 32'(bus_if.frame_err), 32'd0);
        check("rst_ovr", 32'(bus_if.overrun), 32'd0);
        check("rst_busy", 32'(bus_if.busy), 32'd0);
        rxd = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        check("idle_busy", 32'(bus_if.busy), 32'd0);
        check("idle_valid", 32'(bus_if.rx_valid), 32'd0);

        // Byte 0xA5 and receive latency
        start_cyc = cyc;
        send_frame(8'hA5, 1'b1, 1'b0);
        check("a5_valid", 32'(bus_if.rx_valid), 32'd1);
        check("a5_data", 32'(bus_if.rx_data), 32'h0000_00A5);
        check("a5_ferr_cnt", 32'(fe_cnt), 32'd0);
        check("a5_ovr", 32'(bus_if.overrun), 32'd0);
        check("a5_latency", 32'((rise_cyc - start_cyc) >= 8242 && (rise_cyc - start_cyc) <= 8250), 32'd1);
        pulse_ack();
        check("a5_ack_valid", 32'(bus_if.rx_valid), 32'd0);

        // 200 ns glitch
        fe0 = fe_cnt;
        rxd = 1'b0;
        repeat (20) @(negedge clk);
        rxd = 1'b1;
        check("gl_busy_hi", 32'(bus_if.busy), 32'd1);
        repeat (600) @(negedge clk);
        check("gl_busy_lo", 32'(bus_if.busy), 32'd0);
        check("gl_valid", 32'(bus_if.rx_valid), 32'd0);
        check("gl_ferr", 32'(fe_cnt - fe0), 32'd0);

        // 0x3C with bad stop bit
        fe0 = fe_cnt;
        send_frame(8'h3C, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        check("fe_pulse", 32'(fe_cnt - fe0), 32'd1);
        check("fe_valid", 32'(bus_if.rx_valid), 32'd0);
        check("fe_busy", 32'(bus_if.busy), 32'd0);

        // Overrun
        send_frame(8'h11, 1'b1, 1'b0);
        check("ov1_valid", 32'(bus_if.rx_valid), 32'd1);
        check("ov1_data", 32'(bus_if.rx_data), 32'h0000_0011);
        check("ov1_ovr", 32'(bus_if.overrun), 32'd0);
        send_frame(8'h22, 1'b1, 1'b0);
        check("ov2_valid", 32'(bus_if.rx_valid), 32'd1);
        check("ov2_data", 32'(bus_if.rx_data), 32'h0000_0022);
        check("ov2_ovr", 32'(bus_if.overrun), 32'd1);
        pulse_ack();
        check("ov_ack_valid", 32'(bus_if.rx_valid), 32'd0);
        check("ov_ack_ovr", 32'(bus_if.overrun), 32'd0);

        // Back-to-back frames, zero idle gap
        fe0 = fe_cnt;
        send_frame(8'h00, 1'b1, 1'b1);
        send_frame(8'hFF, 1'b1, 1'b1);
        send_frame(8'h55, 1'b1, 1'b1);
        repeat (5) @(negedge clk);
        check("bb_ferr", 32'(fe_cnt - fe0), 32'd0);
        check("bb_ovr", 32'(bus_if.overrun), 32'd0);

        // Reset in the middle of DATA
        fe0 = fe_cnt;
        rxd = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        check("mid_busy", 32'(bus_if.busy), 32'd1);
        rst = 1'b0;
        rxd = 1'b1;
        repeat (2) @(negedge clk);
        check("mid_rst_busy", 32'(bus_if.busy), 32'd0);
        rst = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        check("mid_valid", 32'(bus_if.rx_valid), 32'd0);
        check("mid_busy_after", 32'(bus_if.busy), 32'd0);
        check("mid_ferr", 32'(fe_cnt - fe0), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
